// File: rtl/disk_pkg.sv
// Shared types and constants for the emulated disk back end.
package disk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } disk_state_t;

  localparam logic DISK_MODE_READ  = 1'b0;
  localparam logic DISK_MODE_WRITE = 1'b1;
  localparam int   ERR_COUNT_W     = 16;

  function automatic logic [ERR_COUNT_W-1:0] err_sat_add(
    input logic [ERR_COUNT_W-1:0] cnt,
    input logic [1:0]             inc
  );
    logic [ERR_COUNT_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_COUNT_W-1){1'b0}}, inc};
    return sum[ERR_COUNT_W] ? {ERR_COUNT_W{1'b1}} : sum[ERR_COUNT_W-1:0];
  endfunction

endpackage

// File: rtl/disk_ram.sv
// Single-port disk image RAM: byte-lane write enables, registered read.
module disk_ram #(
  parameter int DEPTH_WORDS = 65536,
  parameter     INIT_FILE   = "",
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  initial begin
    for (int k = 0; k < DEPTH_WORDS; k++) mem[k] = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/disk_server.sv
// Emulated disk: one request at a time, fixed latency, saturating error counter.
// Optional DISK_WRITE_PROTECT_EN: writes are answered normally but never reach the RAM.
module disk_server
  import disk_pkg::*;
#(
  parameter int DEPTH_WORDS = 65536,
  parameter int LATENCY     = 4,
  parameter     INIT_FILE   = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_enable,
  input  logic                   req_mode,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_wstrb,
  output logic                   resp_enable,
  output logic [31:0]            resp_data,
  output logic                   busy,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DISK_WRITE_PROTECT_EN
  localparam logic WRITE_PROTECT = 1'b1;
`else
  localparam logic WRITE_PROTECT = 1'b0;
`endif

  disk_state_t   state, state_nxt;
  logic [7:0]    wait_cnt;
  logic          mode_q, oor_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q, resp_hold, resp_sel, ram_rdata;
  logic [3:0]    wstrb_q, ram_we;
  logic          ram_en, overrun, range_err, wp_err, req_oor;
  logic [1:0]    err_inc;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];
  assign req_oor = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 4'h0;
    unique case (state)
      IDLE:   if (req_enable) state_nxt = (LATENCY == 0) ? ACCESS : WAIT;
      WAIT:   if (wait_cnt == 8'd1) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = RESP;
        // reset in the access cycle wins: nothing reaches the RAM
        ram_en = !oor_q && !rst;
        if (mode_q == DISK_MODE_WRITE && !WRITE_PROTECT && !oor_q && !rst) ram_we = wstrb_q;
      end
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign resp_enable = (state == RESP) && !rst;
  assign resp_sel    = (mode_q == DISK_MODE_WRITE || oor_q) ? 32'h0 : ram_rdata;
  assign resp_data   = (state == RESP) ? resp_sel : resp_hold;

  assign overrun   = req_enable && (state != IDLE);
  assign range_err = (state == ACCESS) && oor_q;
  assign wp_err    = (state == ACCESS) && WRITE_PROTECT && (mode_q == DISK_MODE_WRITE);
  assign err_inc   = 2'(overrun) + 2'(range_err) + 2'(wp_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      err_count <= '0;
      resp_hold <= 32'h0;
    end else begin
      state     <= state_nxt;
      err_count <= err_sat_add(err_count, err_inc);
      if (state == IDLE && req_enable) begin
        mode_q   <= req_mode;
        idx_q    <= req_addr[AW+1:2];
        oor_q    <= req_oor;
        wdata_q  <= req_wdata;
        wstrb_q  <= req_wstrb;
        wait_cnt <= 8'(LATENCY);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
      if (state == RESP) resp_hold <= resp_sel;
    end
  end

  disk_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_disk_server.sv
// Bench for disk_server: two instances (latency 4 and 0), per-cycle model compare plus directed literals.
module tb_disk_server;

  localparam int DEPTH = 1024;
`ifdef DISK_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_enable [2];
  logic        req_mode   [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_wstrb  [2];
  logic        resp_enable[2];
  logic [31:0] resp_data  [2];
  logic        busy       [2];
  logic [15:0] err_count  [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  disk_server #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .req_enable(req_enable[0]), .req_mode(req_mode[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .resp_enable(resp_enable[0]), .resp_data(resp_data[0]),
    .busy(busy[0]), .err_count(err_count[0])
  );

  disk_server #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_enable(req_enable[1]), .req_mode(req_mode[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .resp_enable(resp_enable[1]), .resp_data(resp_data[1]),
    .busy(busy[1]), .err_count(err_count[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each accepted request is a scheduled event (access at T+LAT+1, response at T+LAT+2)
  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int LAT = (g == 0) ? 4 : 0;
    logic [31:0] mem [DEPTH];
    bit          pend;
    int          t_acc, t_resp, m_idx, err;
    bit          m_write, m_oor;
    logic [31:0] m_wdata, m_data, last_data;
    logic [3:0]  m_wstrb;

    initial begin
      foreach (mem[k]) mem[k] = 32'h0;
      pend = 0; err = 0; last_data = 32'h0; m_data = 32'h0;
    end

    always @(posedge clk) begin
      int inc;
      logic [31:0] mask;
      inc = 0;
      if (rst) begin
        pend = 0; err = 0; last_data = 32'h0;
      end else begin
        if (req_enable[g]) begin
          if (pend) inc++;
          else begin
            pend    = 1;
            t_acc   = cyc + LAT + 1;
            t_resp  = cyc + LAT + 2;
            m_write = req_mode[g];
            m_idx   = int'(req_addr[g] >> 2);
            m_oor   = (req_addr[g] >> 2) >= DEPTH;
            m_wdata = req_wdata[g];
            m_wstrb = req_wstrb[g];
          end
        end
        if (pend && cyc == t_acc) begin
          m_data = 32'h0;
          if (m_oor) inc++;
          if (m_write && WP) inc++;
          if (!m_oor) begin
            if (!m_write) m_data = mem[m_idx];
            else if (!WP) begin
              mask = {{8{m_wstrb[3]}}, {8{m_wstrb[2]}}, {8{m_wstrb[1]}}, {8{m_wstrb[0]}}};
              mem[m_idx] = (mem[m_idx] & ~mask) | (m_wdata & mask);
            end
          end
        end
        if (pend && cyc == t_resp) begin
          last_data = m_data;
          pend = 0;
        end
        err = (err + inc > 65535) ? 65535 : err + inc;
      end
    end

    always @(negedge clk) begin
      bit due;
      if (cyc >= 2) begin
        due = pend && (cyc == t_resp);
        chk($sformatf("busy[%0d]", g), 32'(busy[g]), 32'(pend));
        chk($sformatf("resp_enable[%0d]", g), 32'(resp_enable[g]), 32'(due && !rst));
        if (!rst) chk($sformatf("resp_data[%0d]", g), resp_data[g], due ? m_data : last_data);
        if (!pend) chk($sformatf("err_count[%0d]", g), 32'(err_count[g]), 32'(err));
      end
    end
  end

  task automatic strobe(input int i, input bit mode, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output int t0);
    @(posedge clk); #1;
    req_enable[i] = 1'b1; req_mode[i] = mode; req_addr[i] = addr;
    req_wdata[i] = wd; req_wstrb[i] = st; t0 = cyc;
    @(posedge clk); #1;
    req_enable[i] = 1'b0;
  endtask

  task automatic xact(input int i, input bit mode, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] data, output int lat);
    int t0;
    bit got;
    strobe(i, mode, addr, wd, st, t0);
    got = 0; data = 32'hxxxx_xxxx; lat = -1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (resp_enable[i]) begin
        got = 1; data = resp_data[i]; lat = cyc - t0;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL response_timeout inst %0d addr %h: got none expected one", i, addr);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int l, t0, n;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_enable[i] = 0; req_mode[i] = 0; req_addr[i] = 0; req_wdata[i] = 0; req_wstrb[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy[0]), 32'h0);
    chk("reset_err", 32'(err_count[0]), 32'h0);
    chk("reset_resp_data", resp_data[0], 32'h0);

    // write then read, latency 4
    xact(0, 1, 32'h10, 32'h1234_5678, 4'hF, d, l);
    chk("t1_wr_latency", l, 6);
    chk("t1_wr_data", d, 32'h0);
    xact(0, 0, 32'h10, 32'h0, 4'h0, d, l);
    chk("t1_rd_data", d, WP ? 32'h0 : 32'h1234_5678);
    chk("t1_err", 32'(err_count[0]), WP ? 32'd1 : 32'd0);

    // partial byte-lane write
    xact(0, 0, 32'h10, 32'h0, 4'h0, d, l);
    chk("t2_rd_before", d, WP ? 32'h0 : 32'h1234_5678);
    xact(0, 1, 32'h10, 32'hAABB_CCDD, 4'b0101, d, l);
    xact(0, 0, 32'h10, 32'h0, 4'h0, d, l);
    chk("t2_rd_merged", d, WP ? 32'h0 : 32'h12BB_56DD);

    // latency 0, back-to-back
    do_reset();
    xact(1, 1, 32'h10, 32'hCAFE_F00D, 4'hF, d, l);
    chk("t3_wr_latency", l, 2);
    xact(1, 0, 32'h10, 32'h0, 4'h0, d, l);
    chk("t3_rd_latency", l, 2);
    chk("t3_rd_data", d, WP ? 32'h0 : 32'hCAFE_F00D);
    chk("t3_err", 32'(err_count[1]), WP ? 32'd1 : 32'd0);

    // overrun two cycles after the first strobe
    do_reset();
    strobe(0, 0, 32'h10, 32'h0, 4'h0, t0);
    strobe(0, 0, 32'h20, 32'h0, 4'h0, t0);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (resp_enable[0]) begin n++; d = resp_data[0]; end
    end
    chk("t4_resp_count", n, 1);
    chk("t4_rd_data", d, WP ? 32'h0 : 32'h12BB_56DD);
    chk("t4_err", 32'(err_count[0]), 32'd1);

    // out of range, no aliasing onto word 0
    do_reset();
    xact(0, 1, 32'h0, 32'h5555_AAAA, 4'hF, d, l);
    xact(0, 0, DEPTH * 4, 32'h0, 4'h0, d, l);
    chk("t5_oor_rd_data", d, 32'h0);
    chk("t5_oor_rd_latency", l, 6);
    chk("t5_err_rd", 32'(err_count[0]), WP ? 32'd2 : 32'd1);
    xact(0, 1, DEPTH * 4, 32'hDEAD_BEEF, 4'hF, d, l);
    xact(0, 0, 32'h0, 32'h0, 4'h0, d, l);
    chk("t5_word0", d, WP ? 32'h0 : 32'h5555_AAAA);
    chk("t5_err_total", 32'(err_count[0]), WP ? 32'd4 : 32'd2);

    // reset during WAIT of a write
    do_reset();
    strobe(0, 1, 32'h10, 32'hFFFF_0000, 4'hF, t0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_busy_after_rst", 32'(busy[0]), 32'h0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_enable[0]) n++;
    end
    chk("t6_no_resp", n, 0);
    xact(0, 0, 32'h10, 32'h0, 4'h0, d, l);
    chk("t6_word_kept", d, WP ? 32'h0 : 32'h12BB_56DD);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
